// File: rtl/fifo_to_tx_if.sv
// CCI-P Tx types used by the drain stage, and the bundle tying the Tx FIFO outputs,
// host almost-full flags and the registered CCI-P Tx port to fifo_to_tx.
package ccip_if_pkg;
    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef struct packed {
        logic [1:0]  vc_sel;
        t_ccip_clLen cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic        sop;
        t_ccip_clLen cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;
endpackage

interface fifo_to_tx_if #(
    parameter int CNT_WIDTH = 32
);
    import ccip_if_pkg::*;

    logic                 in_fifo_c0_notEmpty;
    t_if_ccip_c0_Tx       in_fifo_c0_first;
    logic                 out_fifo_c0_deq_en;
    logic                 in_fifo_c1_notEmpty;
    t_if_ccip_c1_Tx       in_fifo_c1_first;
    logic                 out_fifo_c1_deq_en;
    logic                 in_fifo_c2_notEmpty;
    t_if_ccip_c2_Tx       in_fifo_c2_first;
    logic                 out_fifo_c2_deq_en;
    logic                 c0TxAlmFull;
    logic                 c1TxAlmFull;
    t_if_ccip_Tx          afu_TxPort;
    logic [CNT_WIDTH-1:0] out_c0_cnt;
    logic [CNT_WIDTH-1:0] out_c1_cnt;
    logic [CNT_WIDTH-1:0] out_c2_cnt;

    // master: the drain block; slave: FIFOs plus host side
    modport master (
        input  in_fifo_c0_notEmpty, in_fifo_c0_first,
        input  in_fifo_c1_notEmpty, in_fifo_c1_first,
        input  in_fifo_c2_notEmpty, in_fifo_c2_first,
        input  c0TxAlmFull, c1TxAlmFull,
        output out_fifo_c0_deq_en, out_fifo_c1_deq_en, out_fifo_c2_deq_en,
        output afu_TxPort, out_c0_cnt, out_c1_cnt, out_c2_cnt
    );

    modport slave (
        output in_fifo_c0_notEmpty, in_fifo_c0_first,
        output in_fifo_c1_notEmpty, in_fifo_c1_first,
        output in_fifo_c2_notEmpty, in_fifo_c2_first,
        output c0TxAlmFull, c1TxAlmFull,
        input  out_fifo_c0_deq_en, out_fifo_c1_deq_en, out_fifo_c2_deq_en,
        input  afu_TxPort, out_c0_cnt, out_c1_cnt, out_c2_cnt
    );
endinterface

// File: rtl/fifo_to_tx.sv
// Drains the c0/c1/c2 show-ahead Tx FIFOs into a registered CCI-P Tx port, honouring
// host almost-full while keeping multi-line c1 writes contiguous.
module fifo_to_tx
    import ccip_if_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    fifo_to_tx_if.master bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t               state_reg, state_next;
    logic [1:0]           beats_left_reg, beats_left_next;
    t_if_ccip_Tx          tx_reg, tx_next;
    logic                 c0_deq, c1_deq, c2_deq;
    logic [2:0]           deq;
    logic [CNT_WIDTH-1:0] cnt_reg [3];

    // Gating with reset_n keeps the FIFOs untouched while reset is held
    assign c0_deq = reset_n & bus.in_fifo_c0_notEmpty & ~bus.c0TxAlmFull;
    assign c2_deq = reset_n & bus.in_fifo_c2_notEmpty;

    always_comb begin
        state_next      = state_reg;
        beats_left_next = beats_left_reg;
        c1_deq          = 1'b0;
        case (state_reg)
            IDLE: begin
                c1_deq = reset_n & bus.in_fifo_c1_notEmpty & ~bus.c1TxAlmFull;
                if (c1_deq && bus.in_fifo_c1_first.hdr.sop &&
                    (bus.in_fifo_c1_first.hdr.cl_len == eCL_LEN_2 ||
                     bus.in_fifo_c1_first.hdr.cl_len == eCL_LEN_4)) begin
                    state_next      = BURST;
                    beats_left_next = (bus.in_fifo_c1_first.hdr.cl_len == eCL_LEN_4) ? 2'd3 : 2'd1;
                end
            end
            BURST: begin
                // Almost-full ignored: host slack absorbs the tail of a started packet
                c1_deq = reset_n & bus.in_fifo_c1_notEmpty;
                if (c1_deq) begin
                    beats_left_next = beats_left_reg - 2'd1;
                    if (beats_left_reg == 2'd1) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next                = '0;
        tx_next.c0             = bus.in_fifo_c0_first;
        tx_next.c0.valid       = c0_deq;
        tx_next.c1             = bus.in_fifo_c1_first;
        tx_next.c1.valid       = c1_deq;
        tx_next.c2             = bus.in_fifo_c2_first;
        tx_next.c2.mmioRdValid = c2_deq;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            beats_left_reg <= 2'd0;
            tx_reg         <= '0;
        end else begin
            state_reg      <= state_next;
            beats_left_reg <= beats_left_next;
            tx_reg         <= tx_next;
        end
    end

    assign deq = {c2_deq, c1_deq, c0_deq};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg[gi] <= '0;
                end else if (deq[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    assign bus.out_fifo_c0_deq_en = c0_deq;
    assign bus.out_fifo_c1_deq_en = c1_deq;
    assign bus.out_fifo_c2_deq_en = c2_deq;
    assign bus.afu_TxPort         = tx_reg;
    assign bus.out_c0_cnt         = cnt_reg[0];
    assign bus.out_c1_cnt         = cnt_reg[1];
    assign bus.out_c2_cnt         = cnt_reg[2];
endmodule

// File: tb/tb_fifo_to_tx.sv
// Directed bench for fifo_to_tx: queue-based FIFO models feed the block, outputs are
// compared at the falling edge against hand-computed values.
module tb_fifo_to_tx;
    import ccip_if_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic dq0, dq1, dq2;

    t_if_ccip_c0_Tx c0_q[$];
    t_if_ccip_c1_Tx c1_q[$];
    t_if_ccip_c2_Tx c2_q[$];

    fifo_to_tx_if #(.CNT_WIDTH(32)) bus ();

    fifo_to_tx #(.CNT_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic t_if_ccip_c0_Tx mk_c0(input logic [41:0] addr);
        t_if_ccip_c0_Tx e;
        e             = '0;
        e.hdr.cl_len  = eCL_LEN_1;
        e.hdr.address = addr;
        e.hdr.mdata   = addr[15:0] ^ 16'h5a5a;
        e.valid       = 1'b1;
        return e;
    endfunction

    function automatic t_if_ccip_c1_Tx mk_c1(input logic sop, input t_ccip_clLen len,
                                             input logic [41:0] addr);
        t_if_ccip_c1_Tx e;
        e             = '0;
        e.hdr.sop     = sop;
        e.hdr.cl_len  = len;
        e.hdr.address = addr;
        e.data        = {8{22'h0, addr}};
        e.valid       = 1'b1;
        return e;
    endfunction

    function automatic t_if_ccip_c2_Tx mk_c2(input logic [8:0] tid, input logic [63:0] data);
        t_if_ccip_c2_Tx e;
        e             = '0;
        e.hdr.tid     = tid;
        e.data        = data;
        e.mmioRdValid = 1'b1;
        return e;
    endfunction

    // Present the FIFO heads and let the combinational deq_en settle
    task automatic drive();
        bus.in_fifo_c0_notEmpty = (c0_q.size() != 0);
        bus.in_fifo_c0_first    = (c0_q.size() != 0) ? c0_q[0] : '0;
        bus.in_fifo_c1_notEmpty = (c1_q.size() != 0);
        bus.in_fifo_c1_first    = (c1_q.size() != 0) ? c1_q[0] : '0;
        bus.in_fifo_c2_notEmpty = (c2_q.size() != 0);
        bus.in_fifo_c2_first    = (c2_q.size() != 0) ? c2_q[0] : '0;
        #1;
    endtask

    // One clock: sample deq decisions, pop modelled FIFOs at the edge, return at negedge
    task automatic cycle();
        drive();
        dq0 = bus.out_fifo_c0_deq_en;
        dq1 = bus.out_fifo_c1_deq_en;
        dq2 = bus.out_fifo_c2_deq_en;
        @(posedge clk);
        if (dq0) void'(c0_q.pop_front());
        if (dq1) void'(c1_q.pop_front());
        if (dq2) void'(c2_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n         = 1'b0;
        bus.c0TxAlmFull = 1'b0;
        bus.c1TxAlmFull = 1'b0;
        drive();
        repeat (2) @(negedge clk);

        // Reset state: everything zero and no pops even with data waiting
        c0_q.push_back(mk_c0(42'h1));
        c1_q.push_back(mk_c1(1'b1, eCL_LEN_1, 42'h1));
        c2_q.push_back(mk_c2(9'h1, 64'h1));
        drive();
        check("rst_tx_zero", 64'(bus.afu_TxPort == '0), 64'd1);
        check("rst_c0_deq", 64'(bus.out_fifo_c0_deq_en), 64'd0);
        check("rst_c1_deq", 64'(bus.out_fifo_c1_deq_en), 64'd0);
        check("rst_c2_deq", 64'(bus.out_fifo_c2_deq_en), 64'd0);
        check("rst_cnt0", 64'(bus.out_c0_cnt), 64'd0);
        c0_q.delete(); c1_q.delete(); c2_q.delete();
        drive();
        @(negedge clk);
        reset_n = 1'b1;

        // c0 stream of 5
        for (int i = 0; i < 5; i++) c0_q.push_back(mk_c0(42'h100 + 42'(i)));
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("c0s_deq", 64'(dq0), 64'd1);
            check("c0s_valid", 64'(bus.afu_TxPort.c0.valid), 64'd1);
            check("c0s_addr", 64'(bus.afu_TxPort.c0.hdr.address), 64'h100 + 64'(i));
            check("c0s_mdata", 64'(bus.afu_TxPort.c0.hdr.mdata), 64'(16'h5a5a ^ (16'h100 + 16'(i))));
        end
        cycle();
        check("c0s_idle_valid", 64'(bus.afu_TxPort.c0.valid), 64'd0);
        check("c0s_cnt", 64'(bus.out_c0_cnt), 64'd5);

        // c0 throttle: 2 beats, 4 held cycles, 3 beats
        for (int i = 0; i < 5; i++) c0_q.push_back(mk_c0(42'h200 + 42'(i)));
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("c0t_addr", 64'(bus.afu_TxPort.c0.hdr.address), 64'h200 + 64'(i));
        end
        bus.c0TxAlmFull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("c0t_hold_deq", 64'(dq0), 64'd0);
            check("c0t_hold_valid", 64'(bus.afu_TxPort.c0.valid), 64'd0);
        end
        bus.c0TxAlmFull = 1'b0;
        for (int i = 2; i < 5; i++) begin
            cycle();
            check("c0t_valid", 64'(bus.afu_TxPort.c0.valid), 64'd1);
            check("c0t_addr", 64'(bus.afu_TxPort.c0.hdr.address), 64'h200 + 64'(i));
        end
        check("c0t_cnt", 64'(bus.out_c0_cnt), 64'd10);

        // 4-line c1 burst; almost-full rises after beat 1
        c1_q.push_back(mk_c1(1'b1, eCL_LEN_4, 42'h300));
        for (int i = 1; i < 4; i++) c1_q.push_back(mk_c1(1'b0, eCL_LEN_4, 42'h300 + 42'(i)));
        c1_q.push_back(mk_c1(1'b1, eCL_LEN_1, 42'h400));
        cycle();
        check("c1b_valid0", 64'(bus.afu_TxPort.c1.valid), 64'd1);
        check("c1b_addr0", 64'(bus.afu_TxPort.c1.hdr.address), 64'h300);
        bus.c1TxAlmFull = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cycle();
            check("c1b_valid", 64'(bus.afu_TxPort.c1.valid), 64'd1);
            check("c1b_addr", 64'(bus.afu_TxPort.c1.hdr.address), 64'h300 + 64'(i));
        end
        check("c1b_data3", bus.afu_TxPort.c1.data[63:0], 64'h303);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("c1b_wait_deq", 64'(dq1), 64'd0);
            check("c1b_wait_valid", 64'(bus.afu_TxPort.c1.valid), 64'd0);
        end
        bus.c1TxAlmFull = 1'b0;
        cycle();
        check("c1b_single_addr", 64'(bus.afu_TxPort.c1.hdr.address), 64'h400);
        check("c1b_single_valid", 64'(bus.afu_TxPort.c1.valid), 64'd1);
        check("c1b_cnt", 64'(bus.out_c1_cnt), 64'd5);

        // 2-line burst with a 3-cycle FIFO gap
        c1_q.push_back(mk_c1(1'b1, eCL_LEN_2, 42'h500));
        cycle();
        check("c1g_addr0", 64'(bus.afu_TxPort.c1.hdr.address), 64'h500);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("c1g_gap_valid", 64'(bus.afu_TxPort.c1.valid), 64'd0);
        end
        bus.c1TxAlmFull = 1'b1;
        c1_q.push_back(mk_c1(1'b0, eCL_LEN_2, 42'h501));
        cycle();
        check("c1g_burst_deq", 64'(dq1), 64'd1);
        check("c1g_addr1", 64'(bus.afu_TxPort.c1.hdr.address), 64'h501);
        c1_q.push_back(mk_c1(1'b1, eCL_LEN_1, 42'h600));
        cycle();
        check("c1g_idle_deq", 64'(dq1), 64'd0);
        bus.c1TxAlmFull = 1'b0;
        cycle();
        check("c1g_single_addr", 64'(bus.afu_TxPort.c1.hdr.address), 64'h600);
        check("c1g_cnt", 64'(bus.out_c1_cnt), 64'd8);

        // c2 under full back-pressure
        bus.c0TxAlmFull = 1'b1;
        bus.c1TxAlmFull = 1'b1;
        c0_q.push_back(mk_c0(42'h2aa));
        for (int i = 0; i < 3; i++) c2_q.push_back(mk_c2(9'(i + 3), 64'habc0 + 64'(i)));
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("c2_valid", 64'(bus.afu_TxPort.c2.mmioRdValid), 64'd1);
            check("c2_data", bus.afu_TxPort.c2.data, 64'habc0 + 64'(i));
            check("c2_tid", 64'(bus.afu_TxPort.c2.hdr.tid), 64'(i + 3));
            check("c2_c0_held", 64'(bus.afu_TxPort.c0.valid), 64'd0);
        end
        cycle();
        check("c2_idle_valid", 64'(bus.afu_TxPort.c2.mmioRdValid), 64'd0);
        check("c2_cnt", 64'(bus.out_c2_cnt), 64'd3);
        bus.c0TxAlmFull = 1'b0;
        bus.c1TxAlmFull = 1'b0;
        cycle();
        check("c2_c0_release", 64'(bus.afu_TxPort.c0.hdr.address), 64'h2aa);
        check("c2_c0_cnt", 64'(bus.out_c0_cnt), 64'd11);

        // Async reset between beats 2 and 3 of a 4-line write
        c1_q.push_back(mk_c1(1'b1, eCL_LEN_4, 42'h700));
        for (int i = 1; i < 4; i++) c1_q.push_back(mk_c1(1'b0, eCL_LEN_4, 42'h700 + 42'(i)));
        cycle();
        cycle();
        check("ar_beat2", 64'(bus.afu_TxPort.c1.hdr.address), 64'h701);
        drive();
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_tx_zero", 64'(bus.afu_TxPort == '0), 64'd1);
        check("ar_c1_deq", 64'(bus.out_fifo_c1_deq_en), 64'd0);
        check("ar_cnt1", 64'(bus.out_c1_cnt), 64'd0);
        c0_q.delete(); c1_q.delete(); c2_q.delete();
        drive();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ar_cnt0", 64'(bus.out_c0_cnt), 64'd0);
        check("ar_cnt2", 64'(bus.out_c2_cnt), 64'd0);
        // In IDLE a new packet must wait for almost-full to drop
        bus.c1TxAlmFull = 1'b1;
        c1_q.push_back(mk_c1(1'b1, eCL_LEN_1, 42'h800));
        @(negedge clk);
        cycle();
        check("ar_idle_deq", 64'(dq1), 64'd0);
        bus.c1TxAlmFull = 1'b0;
        cycle();
        check("ar_single_addr", 64'(bus.afu_TxPort.c1.hdr.address), 64'h800);
        check("ar_cnt1_after", 64'(bus.out_c1_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_to_tx.md
# fifo_to_tx

Drain side of the per-channel CCI-P Tx buffering. The block pops requests from the three show-ahead Tx FIFOs (c0 read requests, c1 write requests, c2 MMIO read responses) and drives a registered `t_if_ccip_Tx` toward the host/FIU. It honours host back-pressure (`c0TxAlmFull`/`c1TxAlmFull`) and keeps multi-line c1 writes contiguous, never splitting them across an almost-full event. It sits between the FIFO outputs of the Tx buffering stage and the physical CCI-P Tx port of the mux.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of the per-channel issued-beat counters.

Ports:
- `clk`  in  1  CCI-P clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_fifo_c0_notEmpty`  in  1  c0 FIFO holds an entry.
- `in_fifo_c0_first`  in  `t_if_ccip_c0_Tx`  c0 FIFO head (show-ahead).
- `out_fifo_c0_deq_en`  out  1  pop c0 FIFO this cycle.
- `in_fifo_c1_notEmpty` / `in_fifo_c1_first` (`t_if_ccip_c1_Tx`) / `out_fifo_c1_deq_en`  as for c0.
- `in_fifo_c2_notEmpty` / `in_fifo_c2_first` (`t_if_ccip_c2_Tx`) / `out_fifo_c2_deq_en`  as for c0.
- `c0TxAlmFull`  in  1  host c0 almost-full (from `t_if_ccip_Rx`).
- `c1TxAlmFull`  in  1  host c1 almost-full.
- `afu_TxPort`  out  `t_if_ccip_Tx`  registered request/response port to the host.
- `out_c0_cnt`, `out_c1_cnt`, `out_c2_cnt`  out  `CNT_WIDTH`  beats issued per channel.

## Operation
- The three channels are independent. No arbitration exists between them; all three may issue in the same cycle.
- c0:
  - `out_fifo_c0_deq_en = in_fifo_c0_notEmpty & ~c0TxAlmFull`.
  - On deq, the head is loaded into the output register with `valid=1`.
  - Otherwise the register loads `valid=0`.
- c2:
  - `out_fifo_c2_deq_en = in_fifo_c2_notEmpty`. MMIO responses are never throttled.
  - On deq, the head is registered with `mmioRdValid=1`; otherwise `mmioRdValid=0`.
- c1 uses a two-state FSM with a 2-bit `beats_left` counter:
  - IDLE:
    - deq when `notEmpty & ~c1TxAlmFull`.
    - If the head has `sop=1` and `cl_len` is eCL_LEN_2 or eCL_LEN_4, load `beats_left` = 1 or 3 and go to BURST.
    - Single-line writes, WrFence, and interrupts remain in IDLE.
  - BURST:
    - deq when `notEmpty`, ignoring `c1TxAlmFull`. The CCI-P post-almost-full slack of 8 covers at most 3 extra beats.
    - Each deq decrements `beats_left`. On the deq that sees `beats_left==1`, return to IDLE.
    - FIFO empty mid-burst: issue no beat (`valid=0`), hold state, resume when non-empty.
  - A head with `sop=0` seen in IDLE is a protocol error. It is issued as a single beat; state stays IDLE.
- Counters:
  - Each counter increments by 1 on every cycle its channel deqs.
  - Counters wrap modulo 2^`CNT_WIDTH`.
- Payload fields of non-valid output beats are don't-care. They are not required to be zero.

## Timing
- Reset (`reset_n` low, asynchronous):
  - all `afu_TxPort` fields 0, including valids and mmioRdValid.
  - FSM in IDLE, `beats_left`=0, counters 0.
  - all `deq_en` outputs 0 while `reset_n` is low, regardless of `notEmpty`.
- Reset mid-burst aborts the burst. Remaining beats stay in the FIFO and are not issued as continuation; the upstream FIFO is reset by the same event.
- Latency: deq in cycle N produces that entry on `afu_TxPort` in cycle N+1. Throughput is 1 beat/cycle/channel.
- `deq_en` is combinational from `notEmpty`, the almost-full inputs, and FSM state. There is no combinational path from FIFO data to `afu_TxPort`.
- Almost-full is sampled in the same cycle as the deq decision. Assertion in cycle N means no new c0 request and no new c1 packet start is dequeued in N.
- Counter value reflects deqs up to and including the previous cycle.

## Test plan
- c0 stream:
  - stimulus: 5 entries, `c0TxAlmFull=0`.
  - required: 5 consecutive `c0.valid` beats, each one cycle after its deq, headers identical; `out_c0_cnt=5`.
- c0 throttle:
  - stimulus: assert `c0TxAlmFull` after 2 beats for 4 cycles, then release.
  - required: no deq and no `valid` during the hold; remaining 3 entries issue in the 3 cycles after release.
- 4-line c1 burst across almost-full:
  - stimulus: write packet (`sop=1`, eCL_LEN_4); `c1TxAlmFull` rises after beat 1.
  - required: all 4 beats issue back-to-back; a following single-line write waits until `c1TxAlmFull=0`.
- 2-line burst with FIFO gap:
  - stimulus: second beat enqueued 3 cycles late.
  - required: FSM stays in BURST, `c1.valid=0` for those cycles, second beat then issues, FSM returns to IDLE.
- c2 under back-pressure:
  - stimulus: both almost-fulls held at 1; 3 MMIO responses queued.
  - required: 3 consecutive `mmioRdValid` beats; `out_c2_cnt=3`.
- Async reset mid-burst:
  - stimulus: drop `reset_n` between beats 2 and 3 of a 4-line write.
  - required: all outputs 0 immediately; after release, FSM is in IDLE and counters are 0.
